mem_access: RTL and testbench



---
 rtl/mem_access.sv | 164 ++++++++++++++++
 tb/tb_mem_access.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MEM pipeline stage: RV32I loads/stores over a req/gnt + rvalid data bus, stalling the core while a
// transaction is outstanding. Optional misaligned-access trap is enabled with MEM_MISALIGN_TRAP_EN.
module mem_access #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_inst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] exe_result,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        freeze_cpu,
  output logic [31:0] mem_result,
  output logic [31:0] wb_inst,
  output logic        misaligned_fault
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RESP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  funct3;
  logic        is_load, is_store, mem_op, legal, trap, go;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [31:0] result_q, inst_q;
  logic        fault_q;

  assign funct3 = mem_inst[14:12];

  always_comb begin
    is_load  = (mem_inst[6:0] == OP_LOAD);
    is_store = (mem_inst[6:0] == OP_STORE);
    mem_op   = is_load || is_store;
    legal    = (is_load  && (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) ||
               (is_store && (funct3 inside {3'b000, 3'b001, 3'b010}));
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // funct3[1:0] is 01 for all halfword ops and 10 for all word ops
  assign trap = legal && (((funct3[1:0] == 2'b01) && mem_addr[0]) ||
                          ((funct3[1:0] == 2'b10) && (mem_addr[1:0] != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  assign go = legal && !trap;

  // Request fields come straight from the held MEM-stage inputs, so they stay stable while waiting.
  always_comb begin
    dmem_addr = {mem_addr[31:2], 2'b00};
    dmem_we   = is_store;
    case (funct3[1:0])
      2'b00: begin
        dmem_wdata = {4{exe_result[7:0]}};
        dmem_wstrb = 4'b0001 << mem_addr[1:0];
      end
      2'b01: begin
        dmem_wdata = {2{exe_result[15:0]}};
        dmem_wstrb = mem_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        dmem_wdata = exe_result;
        dmem_wstrb = 4'b1111;
      end
    endcase
    if (!is_store) dmem_wstrb = 4'b0000;
  end

  always_comb begin
    ld_byte = dmem_rdata[{mem_addr[1:0], 3'b000} +: 8];
    ld_half = mem_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'h0, ld_byte};
      3'b101:  load_data = {16'h0, ld_half};
      default: load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    dmem_req   = 1'b0;
    freeze_cpu = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          dmem_req   = 1'b1;
          freeze_cpu = 1'b1;
          state_nxt  = dmem_gnt ? WAIT_RESP : WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        dmem_req   = 1'b1;
        freeze_cpu = 1'b1;
        if (dmem_gnt) state_nxt = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (dmem_rvalid) state_nxt = IDLE;
        else             freeze_cpu = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // The FSM is already forced to IDLE, but a held load/store must not raise a request in reset.
    if (!rst) begin
      dmem_req   = 1'b0;
      freeze_cpu = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      result_q <= 32'h0;
      inst_q   <= NOP_INST;
      fault_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      fault_q <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            inst_q <= NOP_INST;
          end else begin
            inst_q <= mem_inst;
            if (trap) begin
              result_q <= mem_addr;
              fault_q  <= 1'b1;
            end else if (mem_op) begin
              result_q <= 32'h0;
            end else begin
              result_q <= exe_result;
            end
          end
        end
        WAIT_RESP: begin
          if (dmem_rvalid) begin
            inst_q   <= mem_inst;
            result_q <= is_store ? 32'h0 : load_data;
          end else begin
            inst_q <= NOP_INST;
          end
        end
        default: inst_q <= NOP_INST;
      endcase
    end
  end

  assign mem_result       = result_q;
  assign wb_inst          = inst_q;
  assign misaligned_fault = fault_q;

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access: a transaction-level model predicts bus fields, stall length and
// writeback values per instruction while a bus responder applies random grant/response delays.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_inst, mem_addr, exe_result;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        freeze_cpu;
  logic [31:0] mem_result, wb_inst;
  logic        misaligned_fault;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  mem_access dut (
    .clk(clk), .rst(rst), .mem_inst(mem_inst), .mem_addr(mem_addr), .exe_result(exe_result),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .freeze_cpu(freeze_cpu), .mem_result(mem_result),
    .wb_inst(wb_inst), .misaligned_fault(misaligned_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present one instruction, act as the bus slave (grant after g request cycles, respond r cycles
  // after the grant), then compare against the expected transaction outcome.
  task automatic run_inst(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] rdata, input int g, input int r);
    logic [6:0]  opc;
    logic [2:0]  f3;
    bit          ld, st, mis, trap, go, gnt_seen, done, frz;
    logic [31:0] e_res, e_wdata;
    logic [3:0]  e_strb;
    logic [7:0]  b;
    logic [15:0] h;
    int          req_cnt, frz_cnt, gnt_cyc;
    opc  = inst[6:0];
    f3   = inst[14:12];
    ld   = (opc == 7'b0000011) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    st   = (opc == 7'b0100011) && (f3 inside {3'd0, 3'd1, 3'd2});
    mis  = ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) || (f3 == 3'd2 && addr[1:0] != 2'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    trap = (ld || st) && mis;
`else
    trap = 1'b0;
`endif
    go   = (ld || st) && !trap;
    b    = 8'(rdata >> (8 * addr[1:0]));
    h    = 16'(addr[1] ? (rdata >> 16) : rdata);
    if (trap) e_res = addr;
    else if (ld) begin
      case (f3)
        3'd0:    e_res = {{24{b[7]}}, b};
        3'd1:    e_res = {{16{h[15]}}, h};
        3'd4:    e_res = {24'h0, b};
        3'd5:    e_res = {16'h0, h};
        default: e_res = rdata;
      endcase
    end else if (opc == 7'b0000011 || opc == 7'b0100011) e_res = 32'h0;
    else e_res = data;
    case (f3)
      3'd0:    begin e_wdata = {4{data[7:0]}};  e_strb = 4'b0001 << addr[1:0]; end
      3'd1:    begin e_wdata = {2{data[15:0]}}; e_strb = addr[1] ? 4'hC : 4'h3; end
      default: begin e_wdata = data;            e_strb = 4'hF; end
    endcase
    if (!st) e_strb = 4'h0;

    mem_inst = inst; mem_addr = addr; exe_result = data; dmem_rdata = rdata;
    req_cnt = 0; frz_cnt = 0; gnt_cyc = 0; gnt_seen = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      // Stray responses before the grant must be ignored by the stage.
      dmem_rvalid = gnt_seen ? (c == gnt_cyc + r) : 1'($urandom_range(0, 1));
      dmem_gnt    = 1'b0;
      #1;
      if (dmem_req) begin
        dmem_gnt = (req_cnt == g);
        chk("dmem_addr", dmem_addr, addr & ~32'd3);
        chk("dmem_we", 32'(dmem_we), 32'(st));
        chk("dmem_wstrb", 32'(dmem_wstrb), 32'(e_strb));
        if (st) chk("dmem_wdata", dmem_wdata, e_wdata);
        req_cnt++;
        if (dmem_gnt) begin gnt_seen = 1; gnt_cyc = c; end
      end
      #1;
      frz = freeze_cpu;
      if (frz) frz_cnt++;
      @(posedge clk); #1;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      if (!frz) done = 1;
    end
    chk("completed", 32'(done), 32'd1);
    chk("req_cycles", 32'(req_cnt), go ? 32'(g + 1) : 32'd0);
    chk("freeze_cycles", 32'(frz_cnt), go ? 32'(g + r) : 32'd0);
    chk("mem_result", mem_result, e_res);
    chk("wb_inst", wb_inst, inst);
    chk("misaligned_fault", 32'(misaligned_fault), 32'(trap));
  endtask

  logic [6:0] nonmem_ops [4] = '{7'b0010011, 7'b0110011, 7'b0110111, 7'b1100011};

  initial begin
    logic [31:0] inst;
    int kind;
    rst = 1'b0; mem_inst = NOP; mem_addr = 0; exe_result = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    #12;
    chk("rst_mem_result", mem_result, 32'h0);
    chk("rst_wb_inst", wb_inst, NOP);
    chk("rst_fault", 32'(misaligned_fault), 32'd0);
    mem_inst = 32'h0000_2083; mem_addr = 32'h40;
    #1;
    chk("rst_req_gated", 32'(dmem_req), 32'd0);
    chk("rst_freeze_gated", 32'(freeze_cpu), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; mem_inst = NOP;

    // Directed cases
    run_inst(32'h0050_0093, 32'h0, 32'h5, 32'h0, 0, 1);
    run_inst(32'h0000_2023, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 1);
    run_inst(32'h0000_0083, 32'h103, 32'h0, 32'h80FF_1234, 2, 3);
    run_inst(32'h0000_4083, 32'h103, 32'h0, 32'h80FF_1234, 2, 3);
    run_inst(32'h0000_1023, 32'h202, 32'h0000_ABCD, 32'h0, 1, 1);
    run_inst(32'h0000_5083, 32'h202, 32'h0, 32'hABCD_0000, 0, 2);
    run_inst(32'h0000_2083, 32'h101, 32'h0, 32'h1234_5678, 0, 1);
    run_inst(32'h0000_3083, 32'h300, 32'h77, 32'h0, 0, 1);
    run_inst(32'h0000_7023, 32'h300, 32'h77, 32'h0, 0, 1);
    run_inst(32'h0000_2083, 32'h104, 32'h0, 32'hCAFE_F00D, 0, 1);
    run_inst(32'h0000_2023, 32'h108, 32'h1111_2222, 32'h0, 3, 4);

    // Reset while waiting for a response; the late response afterwards must be ignored.
    mem_inst = 32'h0000_2083; mem_addr = 32'h40; exe_result = 0; dmem_rdata = 32'h5555_AAAA;
    #1;
    dmem_gnt = dmem_req;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    chk("wait_resp_freeze", 32'(freeze_cpu), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_req", 32'(dmem_req), 32'd0);
    chk("midrst_freeze", 32'(freeze_cpu), 32'd0);
    chk("midrst_mem_result", mem_result, 32'h0);
    chk("midrst_wb_inst", wb_inst, NOP);
    @(posedge clk); #1;
    mem_inst = NOP; exe_result = 32'h7; rst = 1'b1; dmem_rvalid = 1'b1;
    #1;
    chk("late_rvalid_req", 32'(dmem_req), 32'd0);
    chk("late_rvalid_freeze", 32'(freeze_cpu), 32'd0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    chk("late_rvalid_result", mem_result, 32'h7);
    chk("late_rvalid_wb", wb_inst, NOP);

    // Randomized mix of ALU ops, loads, stores and illegal encodings
    for (int i = 0; i < 300; i++) begin
      inst = $urandom;
      kind = $urandom_range(0, 3);
      case (kind)
        0: inst[6:0] = nonmem_ops[$urandom_range(0, 3)];
        1: begin inst[6:0] = 7'b0000011; inst[14:12] = 3'($urandom_range(0, 5)); end
        2: begin inst[6:0] = 7'b0100011; inst[14:12] = 3'($urandom_range(0, 2)); end
        default: inst[6:0] = ($urandom_range(0, 1) != 0) ? 7'b0000011 : 7'b0100011;
      endcase
      run_inst(inst, $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
